xhat_reconstructor: RTL and testbench

Decoder-side counterpart of the nth-band predictor. It joins the prediction stream (xtilde) with the dequantized prediction-error stream and reconstructs the sample as xhat = saturate(xtilde + error) in a two-stage pipeline. Each reconstructed sample is tagged with an end-of-block flag. Once per block, the block mean xhatmean is produced, which the next band's predictor consumes.

---
 rtl/xhat_reconstructor.sv | 124 ++++++++++++
 tb/tb_xhat_reconstructor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xhat_reconstructor.sv
// Decoder-side sample reconstruction: joins prediction and dequantized error,
// saturates to the sample range, tags block ends and emits one mean per block.
module xhat_reconstructor #(
   parameter int DATA_WIDTH     = 16,
   parameter int BLOCK_SIZE_LOG = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    xtilde_valid,
   output logic                    xtilde_ready,
   input  logic [DATA_WIDTH:0]     xtilde_data,
   input  logic                    error_valid,
   output logic                    error_ready,
   input  logic [DATA_WIDTH+1:0]   error_data,
   output logic                    xhat_valid,
   input  logic                    xhat_ready,
   output logic [DATA_WIDTH-1:0]   xhat_data,
   output logic                    xhat_last_s,
   output logic                    xhatmean_valid,
   input  logic                    xhatmean_ready,
   output logic [DATA_WIDTH-1:0]   xhatmean_data
);

   localparam int SW = DATA_WIDTH + 3;
   localparam int AW = DATA_WIDTH + BLOCK_SIZE_LOG;

   logic                      s1_valid;
   logic                      s1_last;
   logic [SW-1:0]             s1_sum;
   logic                      s2_valid;
   logic                      s2_last;
   logic [DATA_WIDTH-1:0]     s2_data;
   logic [BLOCK_SIZE_LOG-1:0] cnt;
   logic [AW-1:0]             acc;
   logic                      mean_valid;
   logic [DATA_WIDTH-1:0]     mean_data;

   logic                      s1_load;
   logic                      s2_load;
   logic                      in_fire;
   logic                      xhat_fire;
   logic                      mean_fire;
   logic [SW-1:0]             sum_next;
   logic [DATA_WIDTH-1:0]     clamped;
   logic [AW-1:0]             acc_sum;

   always_comb begin
      mean_fire    = mean_valid & xhatmean_ready;
      // a block's last sample waits until the mean slot is free or draining
      xhat_valid   = s2_valid & ~(s2_last & mean_valid & ~xhatmean_ready);
      xhat_fire    = xhat_valid & xhat_ready;
      s2_load      = ~s2_valid | xhat_fire;
      s1_load      = (~s1_valid | s2_load) & ~rst;
      xtilde_ready = s1_load & error_valid;
      error_ready  = s1_load & xtilde_valid;
      in_fire      = s1_load & xtilde_valid & error_valid;
      sum_next     = {{2{xtilde_data[DATA_WIDTH]}}, xtilde_data}
                   + {error_data[DATA_WIDTH+1], error_data};
      clamped      = s1_sum[DATA_WIDTH-1:0];
      if (s1_sum[SW-1])
         clamped = '0;
      else if (|s1_sum[SW-2:DATA_WIDTH])
         clamped = '1;
      acc_sum      = acc + AW'(s2_data);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_sum   <= '0;
         cnt      <= '0;
      end else if (s1_load) begin
         s1_valid <= in_fire;
         if (in_fire) begin
            s1_sum  <= sum_next;
            s1_last <= (cnt == '1);
            cnt     <= cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_data  <= '0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data <= clamped;
            s2_last <= s1_last;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         mean_valid <= 1'b0;
         mean_data  <= '0;
      end else begin
         if (xhat_fire) begin
            if (s2_last) begin
               acc        <= '0;
               mean_data  <= DATA_WIDTH'(acc_sum >> BLOCK_SIZE_LOG);
               mean_valid <= 1'b1;
            end else begin
               acc <= acc_sum;
               if (mean_fire)
                  mean_valid <= 1'b0;
            end
         end else if (mean_fire) begin
            mean_valid <= 1'b0;
         end
      end
   end

   assign xhat_data      = s2_data;
   assign xhat_last_s    = s2_last;
   assign xhatmean_valid = mean_valid;
   assign xhatmean_data  = mean_data;

endmodule

// File: tb/tb_xhat_reconstructor.sv
// Directed bench for xhat_reconstructor with 16-bit samples and 4-sample
// blocks; monitors collect every xhat and mean transfer for comparison.
module tb_xhat_reconstructor;

   localparam int DW  = 16;
   localparam int BSL = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          xtilde_valid = 1'b0;
   logic          xtilde_ready;
   logic [DW:0]   xtilde_data = '0;
   logic          error_valid = 1'b0;
   logic          error_ready;
   logic [DW+1:0] error_data = '0;
   logic          xhat_valid;
   logic          xhat_ready = 1'b1;
   logic [DW-1:0] xhat_data;
   logic          xhat_last_s;
   logic          xhatmean_valid;
   logic          xhatmean_ready = 1'b1;
   logic [DW-1:0] xhatmean_data;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] oq[$];
   bit            lq[$];
   logic [DW-1:0] mq[$];
   int            mv_cycles = 0;

   logic [DW:0]   vx[8];
   logic [DW+1:0] ve[8];

   xhat_reconstructor #(.DATA_WIDTH(DW), .BLOCK_SIZE_LOG(BSL)) dut (
      .clk(clk), .rst(rst),
      .xtilde_valid(xtilde_valid), .xtilde_ready(xtilde_ready),
      .xtilde_data(xtilde_data),
      .error_valid(error_valid), .error_ready(error_ready),
      .error_data(error_data),
      .xhat_valid(xhat_valid), .xhat_ready(xhat_ready),
      .xhat_data(xhat_data), .xhat_last_s(xhat_last_s),
      .xhatmean_valid(xhatmean_valid), .xhatmean_ready(xhatmean_ready),
      .xhatmean_data(xhatmean_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (xhat_valid && xhat_ready) begin
         oq.push_back(xhat_data);
         lq.push_back(xhat_last_s);
      end
      if (xhatmean_valid) mv_cycles++;
      if (xhatmean_valid && xhatmean_ready) mq.push_back(xhatmean_data);
   end

   task automatic clear_q();
      oq.delete(); lq.delete(); mq.delete(); mv_cycles = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      xtilde_valid = 1'b0; error_valid = 1'b0;
      xhat_ready = 1'b1; xhatmean_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_q();
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // feeds vx/ve[0..n-1]; xhat_ready is held low for the first 'stall' cycles
   task automatic stream(input int n, input int stall, output int acc_stall);
      int k = 0;
      int cyc = 0;
      acc_stall = 0;
      xhat_ready = (stall == 0);
      while (k < n && cyc < 300) begin
         xtilde_valid = 1'b1; error_valid = 1'b1;
         xtilde_data = vx[k]; error_data = ve[k];
         @(negedge clk);
         if (xtilde_ready && error_ready) begin
            k++;
            if (cyc < stall) acc_stall++;
         end
         @(posedge clk); #1;
         cyc++;
         if (cyc >= stall) xhat_ready = 1'b1;
      end
      xtilde_valid = 1'b0; error_valid = 1'b0;
      tests++;
      if (k != n) begin
         fails++;
         $display("FAIL stream_timeout accepted=%0d required=%0d", k, n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      xtilde_valid = 1'b1; error_valid = 1'b1;
      @(negedge clk);
      tests += 6;
      if (xhat_valid !== 1'b0) begin fails++;
         $display("FAIL rst_xhat_valid got=%b exp=0", xhat_valid); end
      if (xhatmean_valid !== 1'b0) begin fails++;
         $display("FAIL rst_mean_valid got=%b exp=0", xhatmean_valid); end
      if (xhat_last_s !== 1'b0) begin fails++;
         $display("FAIL rst_last got=%b exp=0", xhat_last_s); end
      if (xhat_data !== 16'd0) begin fails++;
         $display("FAIL rst_xhat_data got=%0d exp=0", xhat_data); end
      if (xhatmean_data !== 16'd0) begin fails++;
         $display("FAIL rst_mean_data got=%0d exp=0", xhatmean_data); end
      if (xtilde_ready !== 1'b0 || error_ready !== 1'b0) begin fails++;
         $display("FAIL rst_readies got=%b%b exp=00", xtilde_ready, error_ready); end
      xtilde_valid = 1'b0; error_valid = 1'b0;
      do_reset();
   endtask

   task automatic test_basic();
      do_reset();
      xtilde_valid = 1'b1; error_valid = 1'b1;
      xtilde_data = 17'd100; error_data = -18'sd3;
      @(negedge clk);
      tests++;
      if (!(xtilde_ready && error_ready)) begin fails++;
         $display("FAIL basic_accept got=%b%b exp=11", xtilde_ready, error_ready); end
      @(posedge clk); #1;
      xtilde_valid = 1'b0; error_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (xhat_valid !== 1'b0) begin fails++;
         $display("FAIL basic_early got=%b exp=0", xhat_valid); end
      @(negedge clk);
      tests += 3;
      if (xhat_valid !== 1'b1) begin fails++;
         $display("FAIL basic_latency got=%b exp=1", xhat_valid); end
      if (xhat_data !== 16'd97) begin fails++;
         $display("FAIL basic_data got=%0d exp=97", xhat_data); end
      if (xhat_last_s !== 1'b0) begin fails++;
         $display("FAIL basic_last got=%b exp=0", xhat_last_s); end
   endtask

   task automatic test_saturation();
      int a;
      logic [DW-1:0] exp_d[3];
      do_reset();
      vx[0] = 17'd65530;  ve[0] = 18'd20;
      vx[1] = -17'sd5;    ve[1] = 18'd2;
      vx[2] = 17'd0;      ve[2] = 18'd0;
      exp_d[0] = 16'd65535; exp_d[1] = 16'd0; exp_d[2] = 16'd0;
      stream(3, 0, a);
      wait_cyc(4);
      tests++;
      if (oq.size() != 3) begin fails++;
         $display("FAIL sat_count got=%0d exp=3", oq.size()); end
      for (int i = 0; i < 3 && i < oq.size(); i++) begin
         tests++;
         if (oq[i] !== exp_d[i]) begin fails++;
            $display("FAIL sat_data[%0d] got=%0d exp=%0d", i, oq[i], exp_d[i]); end
      end
   endtask

   task automatic test_block_mean();
      int a;
      logic [DW-1:0] exp_d[4];
      do_reset();
      vx[0] = 17'd10; ve[0] = 18'd0;
      vx[1] = 17'd11; ve[1] = 18'd0;
      vx[2] = 17'd10; ve[2] = 18'd2;
      vx[3] = 17'd20; ve[3] = -18'sd6;
      exp_d[0] = 16'd10; exp_d[1] = 16'd11; exp_d[2] = 16'd12; exp_d[3] = 16'd14;
      stream(4, 0, a);
      wait_cyc(5);
      tests++;
      if (oq.size() != 4) begin fails++;
         $display("FAIL mean_count got=%0d exp=4", oq.size()); end
      for (int i = 0; i < 4 && i < oq.size(); i++) begin
         tests += 2;
         if (oq[i] !== exp_d[i]) begin fails++;
            $display("FAIL mean_data[%0d] got=%0d exp=%0d", i, oq[i], exp_d[i]); end
         if (lq[i] !== (i == 3)) begin fails++;
            $display("FAIL mean_last[%0d] got=%b exp=%b", i, lq[i], i == 3); end
      end
      tests += 2;
      if (mq.size() != 1 || mq[0] !== 16'd11) begin fails++;
         $display("FAIL mean_value n=%0d got=%0d exp=11", mq.size(),
                  mq.size() > 0 ? mq[0] : 16'd0); end
      if (mv_cycles != 1) begin fails++;
         $display("FAIL mean_pulse got=%0d cycles exp=1", mv_cycles); end
   endtask

   task automatic test_back_pressure();
      int a;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         vx[i] = 17'(1000 + 3 * i); ve[i] = 18'd0;
      end
      stream(8, 5, a);
      wait_cyc(6);
      tests += 2;
      if (a != 2) begin fails++;
         $display("FAIL bp_accepted got=%0d exp=2", a); end
      if (oq.size() != 8) begin fails++;
         $display("FAIL bp_count got=%0d exp=8", oq.size()); end
      for (int i = 0; i < 8 && i < oq.size(); i++) begin
         tests += 2;
         if (oq[i] !== 16'(1000 + 3 * i)) begin fails++;
            $display("FAIL bp_data[%0d] got=%0d exp=%0d", i, oq[i], 1000 + 3 * i); end
         if (lq[i] !== (i % 4 == 3)) begin fails++;
            $display("FAIL bp_last[%0d] got=%b exp=%b", i, lq[i], i % 4 == 3); end
      end
   endtask

   task automatic test_mean_stall();
      int a;
      logic [DW-1:0] exp_d[8];
      do_reset();
      xhatmean_ready = 1'b0;
      exp_d[0] = 4;  exp_d[1] = 8;  exp_d[2] = 12; exp_d[3] = 16;
      exp_d[4] = 20; exp_d[5] = 20; exp_d[6] = 20; exp_d[7] = 21;
      for (int i = 0; i < 8; i++) begin
         vx[i] = {1'b0, exp_d[i]}; ve[i] = 18'd0;
      end
      stream(8, 0, a);
      wait_cyc(4);
      @(negedge clk);
      tests += 4;
      if (oq.size() != 7) begin fails++;
         $display("FAIL ms_withheld_count got=%0d exp=7", oq.size()); end
      if (xhat_valid !== 1'b0) begin fails++;
         $display("FAIL ms_xhat_valid got=%b exp=0", xhat_valid); end
      if (xhatmean_valid !== 1'b1) begin fails++;
         $display("FAIL ms_mean_valid got=%b exp=1", xhatmean_valid); end
      if (xhatmean_data !== 16'd10) begin fails++;
         $display("FAIL ms_mean1_hold got=%0d exp=10", xhatmean_data); end
      @(posedge clk); #1;
      xhatmean_ready = 1'b1;
      wait_cyc(4);
      tests += 2;
      if (mq.size() != 2 || mq[0] !== 16'd10 || mq[1] !== 16'd20) begin fails++;
         $display("FAIL ms_means n=%0d got=%0d,%0d exp=10,20", mq.size(),
                  mq.size() > 0 ? mq[0] : 16'd0, mq.size() > 1 ? mq[1] : 16'd0); end
      if (oq.size() != 8) begin fails++;
         $display("FAIL ms_count got=%0d exp=8", oq.size()); end
      for (int i = 0; i < 8 && i < oq.size(); i++) begin
         tests++;
         if (oq[i] !== exp_d[i] || lq[i] !== (i % 4 == 3)) begin fails++;
            $display("FAIL ms_out[%0d] got=%0d/%b exp=%0d/%b", i, oq[i], lq[i],
                     exp_d[i], i % 4 == 3); end
      end
   endtask

   task automatic test_reset_mid_block();
      int a;
      do_reset();
      vx[0] = 17'd50; ve[0] = 18'd0;
      vx[1] = 17'd60; ve[1] = 18'd0;
      stream(2, 100, a);
      @(negedge clk);
      tests++;
      if (xhat_valid !== 1'b1) begin fails++;
         $display("FAIL rmb_inflight got=%b exp=1", xhat_valid); end
      xtilde_valid = 1'b1; error_valid = 1'b1;
      #2 rst = 1'b1;
      #1;
      tests += 2;
      if (xhat_valid !== 1'b0 || xhatmean_valid !== 1'b0) begin fails++;
         $display("FAIL rmb_valids got=%b%b exp=00", xhat_valid, xhatmean_valid); end
      if (xtilde_ready !== 1'b0 || error_ready !== 1'b0) begin fails++;
         $display("FAIL rmb_readies got=%b%b exp=00", xtilde_ready, error_ready); end
      xtilde_valid = 1'b0; error_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; xhat_ready = 1'b1;
      clear_q();
      for (int i = 0; i < 4; i++) begin
         vx[i] = 17'd8; ve[i] = 18'd0;
      end
      stream(4, 0, a);
      wait_cyc(5);
      tests += 2;
      if (oq.size() != 4) begin fails++;
         $display("FAIL rmb_count got=%0d exp=4", oq.size()); end
      if (mq.size() != 1 || mq[0] !== 16'd8) begin fails++;
         $display("FAIL rmb_mean n=%0d got=%0d exp=8", mq.size(),
                  mq.size() > 0 ? mq[0] : 16'd0); end
      for (int i = 0; i < 4 && i < oq.size(); i++) begin
         tests++;
         if (oq[i] !== 16'd8 || lq[i] !== (i == 3)) begin fails++;
            $display("FAIL rmb_out[%0d] got=%0d/%b exp=8/%b", i, oq[i], lq[i], i == 3); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_block_mean();
      test_back_pressure();
      test_mean_stall();
      test_reset_mid_block();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
